// File: rtl/rv_pkg.sv
// Shared fetch/decode types: queue entry layout and default queue depth.
// WIDTH defaults to 32 unless the build defines it.
`ifndef WIDTH
`define WIDTH 32
`endif

package rv_pkg;

  localparam int unsigned XLEN     = `WIDTH;
  localparam int unsigned FQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; flush beats push and pop in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // Upstream back-pressure must keep pushes away from a full queue.
  no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && !flush && full));

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode; tracks the one-cycle imem read, halt and redirect.
// Optional same-cycle decode bypass when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_instr,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pc_halt,
  output logic             pc_src,
  output logic [WIDTH-1:0] jump_val,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic               infl_valid;
  logic [WIDTH-1:0]   infl_pc;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] head;

  // The word returned this cycle belongs to last cycle's PC, unless that PC was frozen or redirected.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_valid <= 1'b0;
      infl_pc    <= '0;
    end else begin
      infl_valid <= !pc_halt && !redir_valid;
      infl_pc    <= fetch_pc;
    end
  end

  // count + infl_valid >= DEPTH, written against full to avoid a wider adder.
  assign pc_halt  = !redir_valid && (full || (infl_valid && (count == CW'(DEPTH - 1))));
  assign pc_src   = redir_valid;
  assign jump_val = redir_pc;
  assign pop      = !empty && dec_ready && !redir_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  assign bypass    = empty && infl_valid && !redir_valid;
  assign push      = infl_valid && !redir_valid && !(bypass && dec_ready);
  assign dec_valid = !empty || bypass;
  assign dec_pc    = bypass ? infl_pc     : head[2*WIDTH-1:WIDTH];
  assign dec_instr = bypass ? fetch_instr : head[WIDTH-1:0];
`else
  assign push      = infl_valid && !redir_valid;
  assign dec_valid = !empty;
  assign dec_pc    = head[2*WIDTH-1:WIDTH];
  assign dec_instr = head[WIDTH-1:0];
`endif

  sync_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redir_valid),
    .wr_data ({infl_pc, fetch_instr}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule
